// File: rtl/inst_fetch_if.sv
// Fetch unit bus: memory read port, redirect input and
// the instruction slot toward decode.
interface inst_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        down_stall;
  logic        to_valid;
  logic [31:0] to_inst;
  logic [31:0] to_pc;
  logic [31:0] to_npc;

  modport master (
    output mem_req, mem_addr,
    output to_valid, to_inst, to_pc, to_npc,
    input  mem_ready, mem_data,
    input  jump_en, jump_addr, down_stall
  );

  modport slave (
    input  mem_req, mem_addr,
    input  to_valid, to_inst, to_pc, to_npc,
    output mem_ready, mem_data,
    output jump_en, jump_addr, down_stall
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, direct-mapped one-word-per-line
// icache, single outstanding miss, redirect support.
module inst_fetch #(
  parameter int          ICACHE_LINES = 16,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input logic          clk_in,
  input logic          rst_in,
  input logic          rdy_in,
  inst_fetch_if.master bus
);
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, MISS} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        vld_q, vld_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] npc_q, npc_d;

  logic [ICACHE_LINES-1:0] line_v;
  logic [TAG_W-1:0]        tag_mem [ICACHE_LINES];
  logic [31:0]             data_mem [ICACHE_LINES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             hit, slot_free, xfer, fill;
  logic             unused_ok;

  assign rd_idx = pc_q[IDX_W+1:2];
  assign rd_tag = pc_q[31:IDX_W+2];
  assign wr_idx = addr_q[IDX_W+1:2];
  assign wr_tag = addr_q[31:IDX_W+2];

  assign hit       = line_v[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign xfer      = vld_q && !bus.down_stall;
  assign slot_free = !vld_q || !bus.down_stall;
  assign fill      = (state_q == MISS) && bus.mem_ready;

  assign unused_ok = ^{addr_q[1:0], bus.jump_addr[1:0]};

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst_in)
      state_q <= IDLE;
    else if (rdy_in)
      state_q <= state_d;
  end

  // Next state, fetch slot and request generation
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    vld_d   = vld_q && !xfer;
    inst_d  = inst_q;
    opc_d   = opc_q;
    npc_d   = npc_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.jump_en) begin
          if (hit) begin
            if (slot_free) begin
              vld_d  = 1'b1;
              inst_d = data_mem[rd_idx];
              opc_d  = pc_q;
              npc_d  = pc_q + 32'd4;
              pc_d   = pc_q + 32'd4;
            end
          end else begin
            req_d   = 1'b1;
            addr_d  = {pc_q[31:2], 2'b00};
            state_d = MISS;
          end
        end
      end
      MISS: begin
        if (bus.mem_ready) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
    if (bus.jump_en) begin
      pc_d  = {bus.jump_addr[31:2], 2'b00};
      vld_d = 1'b0;
    end
  end

  // PC, request and output slot registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_q   <= RESET_PC;
      req_q  <= 1'b0;
      addr_q <= '0;
      vld_q  <= 1'b0;
      inst_q <= '0;
      opc_q  <= '0;
      npc_q  <= '0;
    end else if (rdy_in) begin
      pc_q   <= pc_d;
      req_q  <= req_d;
      addr_q <= addr_d;
      vld_q  <= vld_d;
      inst_q <= inst_d;
      opc_q  <= opc_d;
      npc_q  <= npc_d;
    end
  end

  // Line valid bits, cleared only by reset
  always_ff @(posedge clk_in) begin
    if (rst_in)
      line_v <= '0;
    else if (rdy_in && fill)
      line_v[wr_idx] <= 1'b1;
  end

  // Tag and data arrays written on miss return
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && fill) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= bus.mem_data;
    end
  end

  assign bus.mem_req  = req_q;
  assign bus.mem_addr = addr_q;
  assign bus.to_valid = vld_q;
  assign bus.to_inst  = inst_q;
  assign bus.to_pc    = opc_q;
  assign bus.to_npc   = npc_q;
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch unit that produces the raw 32-bit instruction word and its PC/next-PC consumed by the decoder.
It holds the program counter and a small direct-mapped instruction cache, and issues word reads to the memory controller on a miss.
It presents one instruction at a time on a valid/stall handshake toward decode/dispatch, and accepts redirects from branch/jump resolution.

Parameters:
ICACHE_LINES, 16, number of one-word cache lines (power of two, >=2); index = pc[log2(ICACHE_LINES)+1:2], tag = remaining upper pc bits.
RESET_PC, 32'h0, PC value loaded on reset.

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; when 0 all state holds
mem_req  output  1  word-read request to memory controller
mem_addr  output  32  word address of request (bits [1:0] = 0)
mem_ready  input  1  one-cycle pulse: mem_data valid for mem_addr
mem_data  input  32  returned instruction word
jump_en  input  1  redirect fetch this cycle
jump_addr  input  32  redirect target
down_stall  input  1  consumer cannot accept this cycle
to_valid  output  1  to_inst/to_pc/to_npc hold a valid instruction
to_inst  output  32  raw instruction word (decoder up_inst)
to_pc  output  32  address of to_inst
to_npc  output  32  to_pc + 4, modulo 2^32 (decoder up_npc)

Behaviour:
- One clock. rst_in synchronous, active-high, takes priority over rdy_in.
- Reset values: pc=RESET_PC, state=IDLE, all line-valid bits 0, mem_req=0, mem_addr=0, to_valid=0, to_inst=0, to_pc=0, to_npc=0.
- rdy_in=0 and no reset: every register holds. The memory controller shares rdy_in and gives no mem_ready while it is low.
- Slot handshake: the output slot is "free" when to_valid=0 or (to_valid=1 and down_stall=0). A transfer occurs on an edge with to_valid=1 and down_stall=0. Outputs are registered and stable while to_valid=1 and down_stall=1.
- States:
  - IDLE:
    - Lookup pc in the cache.
    - On a hit with the slot free: to_inst=line data, to_pc=pc, to_npc=pc+4, to_valid=1, pc=pc+4. Hit latency is 1 cycle, giving 1 instruction/cycle sustained.
    - On a hit with the slot not free: hold.
    - On a miss: to_valid goes 0 if it is being transferred; mem_req=1, mem_addr={pc[31:2],2'b00}; go to MISS.
  - MISS:
    - mem_req and mem_addr are held until mem_ready.
    - On mem_ready: write mem_data and tag into line index(mem_addr), set its valid bit, set mem_req=0, go to IDLE.
    - The next IDLE cycle hits. Total miss-to-valid latency = memory latency + 2 cycles.
- Redirect (jump_en=1, not in reset), highest priority:
  - pc = {jump_addr[31:2],2'b00}; to_valid=0 (a pending transfer in the same cycle is cancelled). No instruction from the old path is emitted afterwards.
  - In MISS: the outstanding request is not aborted; mem_req/mem_addr stay asserted until mem_ready. The returned word is still written to the cache at its own address, then the FSM returns to IDLE at the new pc.
  - jump_en coinciding with mem_ready: cache fill occurs, redirect applies, state=IDLE.
- Cache: direct-mapped, no invalidation other than reset. Self-modifying code is not supported.
- pc increments wrap modulo 2^32; 32'hFFFFFFFC is followed by 0.
- Exactly one request outstanding at a time; mem_req never drops before mem_ready.

Test Plan:
1. Reset, then memory returns 32'h00000013 with 3-cycle latency for address 0 -> mem_req=1 with mem_addr=0 the cycle after reset release; to_valid=1, to_inst=32'h13, to_pc=0, to_npc=4 two cycles after mem_ready; next fetch is at 4.
2. Addresses 0..12 preloaded by one pass, then jump_en to 0, down_stall=0 -> four consecutive cycles of to_valid=1 with to_pc=0,4,8,12 and no mem_req.
3. down_stall=1 for 5 cycles while to_valid=1 with to_pc=8 -> outputs stay constant at to_pc=8; pc does not advance; to_pc=12 appears the cycle after down_stall falls.
4. jump_en with jump_addr=32'h1003 during MISS for 0x40 -> mem_req stays high until mem_ready; line for 0x40 is filled; no instruction at 0x40 is emitted; next request has mem_addr=32'h1000.
5. Addresses 0x00 and 0x40 both map to index 0 (ICACHE_LINES=16): fetch 0x00, jump to 0x40, jump to 0x00 -> three misses, with mem_addr 0x00, 0x40, 0x00.
6. rdy_in=0 for 4 cycles mid-hit-stream, then rst_in=1 during MISS -> all state frozen during the pause; after reset, all outputs are 0, mem_req=0, and the first fetch misses at RESET_PC.
